romulus_tbc_sequencer: RTL and testbench

Command-driven controller for the Romulus masked datapath. It converts one-command-at-a-time requests from the mode FSM into cycle-exact control strobes for the datapath registers:
- state, TKX, TKY and TKZ enables, clears and mode selects
- TBC-vs-correction select and counter-correction select
- share enables, share-ring phase
- round constant and domain byte

It owns the round counter, the Skinny 6-bit round-constant LFSR and the ring phase, so that the mode FSM only issues high-level operations.

---
 rtl/romulus_tbc_sequencer_pkg.sv | 36 +++
 rtl/romulus_tbc_sequencer_rc_lfsr.sv | 23 ++
 rtl/romulus_tbc_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_romulus_tbc_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_tbc_sequencer_pkg.sv
// Shared encodings, default configuration and helpers for the Romulus TBC sequencer.
package romulus_tbc_sequencer_pkg;

   localparam logic [2:0] OP_KEY     = 3'd0;
   localparam logic [2:0] OP_TWEAK   = 3'd1;
   localparam logic [2:0] OP_ABSORB  = 3'd2;
   localparam logic [2:0] OP_TBC     = 3'd3;
   localparam logic [2:0] OP_CORRECT = 3'd4;
   localparam logic [2:0] OP_INCR    = 3'd5;
   localparam logic [2:0] OP_INIT    = 3'd6;
   localparam logic [2:0] OP_NOP     = 3'd7;

   typedef enum logic [3:0] {
      S_IDLE, S_KEY, S_TWEAK, S_ABSORB, S_RUN, S_CORR, S_INCR, S_INIT, S_NOP
   } state_t;

   localparam logic [5:0] RC_INIT = 6'h01;

   localparam int DEF_ROUNDS       = 40;
   localparam int DEF_CLKS_PER_RND = 4;
   localparam int DEF_KEYSHARES    = 2;
   localparam int DEF_STATESHARES  = 2;
   localparam int DEF_BUSW         = 32;

   // Beats needed to move `shares` 128-bit words over a BUSW-wide bus.
   function automatic int beat_count(input int shares, input int busw);
      return (128 * shares) / busw;
   endfunction

   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/romulus_tbc_sequencer_rc_lfsr.sv
// Skinny 6-bit round-constant LFSR with load-init, advance and clear controls.
module skinny_rc_lfsr
   import romulus_tbc_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       adv,
   input  logic       clr,
   output logic [5:0] rc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rc <= '0;
      end else if (load) begin
         rc <= RC_INIT;
      end else if (adv) begin
         rc <= {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
      end
   end

endmodule

// File: rtl/romulus_tbc_sequencer.sv
// Command sequencer for the Romulus masked datapath: one command in, cycle-exact strobes out.
// Define ROMULUS_SEQ_ABORT_EN to add the abort/aborted handshake.
module romulus_tbc_sequencer
   import romulus_tbc_sequencer_pkg::*;
#(
   parameter int ROUNDS       = DEF_ROUNDS,
   parameter int CLKS_PER_RND = DEF_CLKS_PER_RND,
   parameter int KEYSHARES    = DEF_KEYSHARES,
   parameter int STATESHARES  = DEF_STATESHARES,
   parameter int BUSW         = DEF_BUSW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [2:0]              cmd_op,
   input  logic [7:0]              cmd_domain,
   input  logic                    cmd_iv,
   input  logic                    bus_valid,
   output logic                    bus_ready,
   output logic                    done,
`ifdef ROMULUS_SEQ_ABORT_EN
   input  logic                    abort,
   output logic                    aborted,
`endif
   output logic                    srst,
   output logic                    senc,
   output logic                    sen,
   output logic                    xrst,
   output logic                    xenc,
   output logic                    xen,
   output logic                    yrst,
   output logic                    yenc,
   output logic                    yen,
   output logic                    zrst,
   output logic                    zenc,
   output logic                    zen,
   output logic                    erst,
   output logic                    correct_cnt,
   output logic                    iv,
   output logic [1:0]              share_en,
   output logic [CLKS_PER_RND-1:0] ring_en,
   output logic [5:0]              constant,
   output logic [7:0]              domain
);

   localparam int KEY_BEATS   = beat_count(KEYSHARES, BUSW);
   localparam int TWEAK_BEATS = beat_count(1, BUSW);
   localparam int STATE_BEATS = beat_count(STATESHARES, BUSW);
   localparam int CNT_W       = $clog2(max_of3(ROUNDS, KEY_BEATS, STATE_BEATS) + 1);

   localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BEATS - 1);
   localparam logic [CNT_W-1:0] TWEAK_LAST = CNT_W'(TWEAK_BEATS - 1);
   localparam logic [CNT_W-1:0] STATE_LAST = CNT_W'(STATE_BEATS - 1);
   localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUNDS - 1);
   localparam logic [CNT_W-1:0] CORR_LAST  = CNT_W'(KEYSHARES - 1);

   if (ROUNDS > 63) begin : g_rounds_check
      $error("romulus_tbc_sequencer: ROUNDS above 63 is not supported");
   end
   if (CLKS_PER_RND < 2 || KEYSHARES < 1 || KEYSHARES > 2) begin : g_cfg_check
      $error("romulus_tbc_sequencer: CLKS_PER_RND must be >= 2 and KEYSHARES 1 or 2");
   end

   state_t                  state, state_next;
   logic [CNT_W-1:0]        cnt;
   logic [CLKS_PER_RND-1:0] ring;
   logic                    iv_q, done_q;
   logic [7:0]              domain_q;
   logic                    accept, cnt_clr, cnt_inc, fin, stop, abort_hit;
   logic                    rc_load, rc_adv, ring_load, ring_rot;
   logic                    ring_top;
   logic [5:0]              rc;

   assign ring_top = ring[CLKS_PER_RND-1];
   // Any transition back to IDLE (normal finish or abort) retires the ring and constant.
   assign stop     = (state != S_IDLE) && (state_next == S_IDLE);

`ifdef ROMULUS_SEQ_ABORT_EN
   assign abort_hit = abort && (state != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      state_next  = state;
      cmd_ready   = 1'b0;
      bus_ready   = 1'b0;
      srst        = 1'b0;
      senc        = 1'b0;
      sen         = 1'b0;
      xrst        = 1'b0;
      xenc        = 1'b0;
      xen         = 1'b0;
      yrst        = 1'b0;
      yenc        = 1'b0;
      yen         = 1'b0;
      zrst        = 1'b0;
      zenc        = 1'b0;
      zen         = 1'b0;
      correct_cnt = 1'b0;
      iv          = 1'b0;
      share_en    = 2'b00;
      accept      = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      fin         = 1'b0;
      rc_load     = 1'b0;
      rc_adv      = 1'b0;
      ring_load   = 1'b0;
      ring_rot    = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept  = 1'b1;
               cnt_clr = 1'b1;
               case (cmd_op)
                  OP_KEY:     state_next = S_KEY;
                  OP_TWEAK:   state_next = S_TWEAK;
                  OP_ABSORB:  state_next = S_ABSORB;
                  OP_TBC: begin
                     state_next = S_RUN;
                     rc_load    = 1'b1;
                     ring_load  = 1'b1;
                  end
                  OP_CORRECT: state_next = S_CORR;
                  OP_INCR:    state_next = S_INCR;
                  OP_INIT:    state_next = S_INIT;
                  default:    state_next = S_NOP;
               endcase
            end
         end
         S_KEY: begin
            bus_ready = bus_valid;
            xrst      = bus_valid;
            cnt_inc   = bus_valid;
            fin       = bus_valid && (cnt == KEY_LAST);
         end
         S_TWEAK: begin
            bus_ready = bus_valid;
            yrst      = bus_valid;
            cnt_inc   = bus_valid;
            fin       = bus_valid && (cnt == TWEAK_LAST);
         end
         S_ABSORB: begin
            bus_ready = bus_valid;
            sen       = 1'b1;
            iv        = iv_q;
            cnt_inc   = bus_valid;
            fin       = bus_valid && (cnt == STATE_LAST);
         end
         S_RUN: begin
            sen      = 1'b1;
            xen      = 1'b1;
            senc     = 1'b1;
            xenc     = 1'b1;
            yenc     = 1'b1;
            zenc     = 1'b1;
            yen      = ring_top;
            zen      = ring_top;
            ring_rot = 1'b1;
            rc_adv   = ring_top;
            cnt_inc  = ring_top;
            fin      = ring_top && (cnt == ROUND_LAST);
         end
         S_CORR: begin
            xen      = 1'b1;
            share_en = (cnt == '0) ? 2'b01 : 2'b10;
            yen      = (cnt == '0);
            zen      = (cnt == '0);
            cnt_inc  = 1'b1;
            fin      = (cnt == CORR_LAST);
         end
         S_INCR: begin
            zen         = 1'b1;
            correct_cnt = 1'b1;
            fin         = 1'b1;
         end
         S_INIT: begin
            zrst = 1'b1;
            srst = 1'b1;
            fin  = 1'b1;
         end
         S_NOP:   fin = 1'b1;
         default: state_next = S_IDLE;
      endcase
      if (fin || abort_hit) state_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         ring     <= '0;
         domain_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= fin && !abort_hit;
         if (cnt_clr) cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CNT_W'(1);
         if (stop) ring <= '0;
         else if (ring_load) ring <= CLKS_PER_RND'(1);
         else if (ring_rot) ring <= {ring[CLKS_PER_RND-2:0], ring_top};
         if (accept) domain_q <= cmd_domain;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) iv_q <= cmd_iv;
   end

`ifdef ROMULUS_SEQ_ABORT_EN
   logic aborted_q;
   always_ff @(posedge clk) begin
      if (rst) aborted_q <= 1'b0;
      else aborted_q <= abort_hit;
   end
   assign aborted = aborted_q;
`endif

   skinny_rc_lfsr u_rc (
      .clk  (clk),
      .rst  (rst),
      .load (rc_load),
      .adv  (rc_adv),
      .clr  (stop),
      .rc   (rc)
   );

   assign done     = done_q;
   assign erst     = rst;
   assign ring_en  = ring;
   assign constant = rc;
   assign domain   = domain_q;

endmodule

// File: tb/tb_romulus_tbc_sequencer.sv
// Scoreboard bench for romulus_tbc_sequencer (abort scenario built with ROMULUS_SEQ_ABORT_EN).
module tb_romulus_tbc_sequencer;
   import romulus_tbc_sequencer_pkg::*;

   localparam int ROUNDS  = 40;
   localparam int CPR     = 4;
   localparam int RUN_CYC = ROUNDS * CPR;

   logic       clk = 1'b0;
   logic       rst, cmd_valid, cmd_iv, bus_valid;
   logic [2:0] cmd_op;
   logic [7:0] cmd_domain;
   logic       cmd_ready, bus_ready, done;
   logic       srst, senc, sen, xrst, xenc, xen, yrst, yenc, yen, zrst, zenc, zen, erst;
   logic       correct_cnt, iv;
   logic [1:0] share_en;
   logic [3:0] ring_en;
   logic [5:0] constant;
   logic [7:0] domain;
`ifdef ROMULUS_SEQ_ABORT_EN
   logic       abort, aborted;
`endif

   logic [35:0] all_outs;
   assign all_outs = {bus_ready, done, srst, senc, sen, xrst, xenc, xen, yrst, yenc, yen,
                      zrst, zenc, zen, correct_cnt, iv, share_en, ring_en, constant, domain};

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   int exp_done_q[$];

   // Published Skinny round constants, rounds 1..40.
   logic [5:0] rc_tab [40] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
                              6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
                              6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
                              6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38,
                              6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   romulus_tbc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_domain  (cmd_domain),
      .cmd_iv      (cmd_iv),
      .bus_valid   (bus_valid),
      .bus_ready   (bus_ready),
      .done        (done),
`ifdef ROMULUS_SEQ_ABORT_EN
      .abort       (abort),
      .aborted     (aborted),
`endif
      .srst        (srst),
      .senc        (senc),
      .sen         (sen),
      .xrst        (xrst),
      .xenc        (xenc),
      .xen         (xen),
      .yrst        (yrst),
      .yenc        (yenc),
      .yen         (yen),
      .zrst        (zrst),
      .zenc        (zenc),
      .zen         (zen),
      .erst        (erst),
      .correct_cnt (correct_cnt),
      .iv          (iv),
      .share_en    (share_en),
      .ring_en     (ring_en),
      .constant    (constant),
      .domain      (domain)
   );

   // Drive a command for one cycle and record when its done pulse is due.
   task automatic issue(input logic [2:0] op, input logic [7:0] dom, input logic ivb,
                        input int lat, output int t);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_domain = dom; cmd_iv = ivb;
      #1;
      t = cyc;
      exp_done_q.push_back(t + lat);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      n_cmp++; if (erst !== 1'b1) begin n_fail++; $display("FAIL erst_in_reset: got %b want 1", erst); end
      n_cmp++; if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs); end
      @(posedge clk); #1; rst = 1'b0; #1;
      n_cmp++; if (all_outs !== '0) begin n_fail++; $display("FAIL idle_outs: got %h want 0", all_outs); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", cmd_ready); end
      n_cmp++; if (erst !== 1'b0) begin n_fail++; $display("FAIL erst_idle: got %b want 0", erst); end
   endtask

   task automatic test_tbc();
      int t, e, yen_cnt;
      bit seen;
      logic [3:0] exp_ring;
      yen_cnt = 0; seen = 0;
      issue(OP_TBC, 8'h5A, 1'b0, RUN_CYC + 1, t);
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL tbc_accept_ready: got %b want 1", cmd_ready); end
      for (int rel = 1; rel <= RUN_CYC + 10 && !seen; rel++) begin
         @(posedge clk); #1;
         cmd_valid = (rel >= 10 && rel <= 12); cmd_op = OP_NOP; cmd_domain = 8'hFF;
         #1;
         if (rel <= RUN_CYC) begin
            exp_ring = 4'b0001 << ((rel - 1) % CPR);
            n_cmp++; if (ring_en !== exp_ring) begin n_fail++; $display("FAIL tbc_ring rel %0d: got %b want %b", rel, ring_en, exp_ring); end
            n_cmp++; if (constant !== rc_tab[(rel - 1) / CPR]) begin n_fail++; $display("FAIL tbc_const rel %0d: got %h want %h", rel, constant, rc_tab[(rel - 1) / CPR]); end
            n_cmp++; if ({sen, xen, senc, xenc, yenc, zenc} !== 6'h3F) begin n_fail++; $display("FAIL tbc_enables rel %0d: got %b want 111111", rel, {sen, xen, senc, xenc, yenc, zenc}); end
            n_cmp++; if (yen !== exp_ring[3] || zen !== exp_ring[3]) begin n_fail++; $display("FAIL tbc_yz rel %0d: got %b%b want %b", rel, yen, zen, exp_ring[3]); end
            if (yen === 1'b1) yen_cnt++;
         end
         if (rel == 11) begin
            n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL tbc_busy_ready: got %b want 0", cmd_ready); end
         end
         if (rel == 20) begin
            n_cmp++; if (domain !== 8'h5A) begin n_fail++; $display("FAIL tbc_domain_hold: got %h want 5a", domain); end
         end
         if (done === 1'b1) begin
            seen = 1;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL tbc_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL tbc_done: got cycle %0d want %0d", cyc, e); end end
            n_cmp++; if (ring_en !== 4'b0 || constant !== 6'h0) begin n_fail++; $display("FAIL tbc_exit_clear: got %b/%h want 0/0", ring_en, constant); end
            n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL tbc_done_ready: got %b want 1", cmd_ready); end
         end
      end
      if (!seen) begin n_cmp++; n_fail++; $display("FAIL tbc_done: got timeout want done"); end
      n_cmp++; if (yen_cnt != ROUNDS) begin n_fail++; $display("FAIL tbc_yen_count: got %0d want %0d", yen_cnt, ROUNDS); end
   endtask

   task automatic test_key();
      int t, e, xrst_cnt;
      bit seen;
      xrst_cnt = 0; seen = 0;
      issue(OP_KEY, 8'h11, 1'b0, 16, t);
      for (int rel = 1; rel <= 40 && !seen; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; bus_valid = (rel % 2 == 1);
         #1;
         n_cmp++; if (bus_ready !== (bus_valid && done !== 1'b1)) begin n_fail++; $display("FAIL key_bus_ready rel %0d: got %b want %b", rel, bus_ready, bus_valid); end
         if (xrst === 1'b1) xrst_cnt++;
         if (done === 1'b1) begin
            seen = 1;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL key_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL key_done: got cycle %0d want %0d", cyc, e); end end
         end
      end
      bus_valid = 1'b0;
      if (!seen) begin n_cmp++; n_fail++; $display("FAIL key_done: got timeout want done"); end
      n_cmp++; if (xrst_cnt != 8) begin n_fail++; $display("FAIL key_xrst_count: got %0d want 8", xrst_cnt); end
   endtask

   task automatic test_tweak_absorb();
      int t, e, cnt;
      bit seen;
      cnt = 0; seen = 0;
      issue(OP_TWEAK, 8'h44, 1'b0, 5, t);
      for (int rel = 1; rel <= 20 && !seen; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; bus_valid = 1'b1;
         #1;
         if (yrst === 1'b1) cnt++;
         if (done === 1'b1) begin
            seen = 1;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL tweak_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL tweak_done: got cycle %0d want %0d", cyc, e); end end
         end
      end
      bus_valid = 1'b0;
      if (!seen) begin n_cmp++; n_fail++; $display("FAIL tweak_done: got timeout want done"); end
      n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL tweak_yrst_count: got %0d want 4", cnt); end

      cnt = 0; seen = 0;
      issue(OP_ABSORB, 8'h55, 1'b1, 10, t);
      for (int rel = 1; rel <= 30 && !seen; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0; bus_valid = (rel != 3);
         #1;
         if (bus_ready === 1'b1) cnt++;
         if (rel < 10) begin
            n_cmp++; if ({sen, senc, iv} !== 3'b101) begin n_fail++; $display("FAIL absorb_strobes rel %0d: got %b want 101", rel, {sen, senc, iv}); end
         end
         if (done === 1'b1) begin
            seen = 1;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL absorb_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL absorb_done: got cycle %0d want %0d", cyc, e); end end
            n_cmp++; if (iv !== 1'b0) begin n_fail++; $display("FAIL absorb_iv_idle: got %b want 0", iv); end
         end
      end
      bus_valid = 1'b0;
      if (!seen) begin n_cmp++; n_fail++; $display("FAIL absorb_done: got timeout want done"); end
      n_cmp++; if (cnt != 8) begin n_fail++; $display("FAIL absorb_beats: got %0d want 8", cnt); end
   endtask

   task automatic test_corr();
      int t, e;
      bit seen;
      seen = 0;
      issue(OP_CORRECT, 8'h22, 1'b0, 3, t);
      for (int rel = 1; rel <= 10 && !seen; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         #1;
         if (rel == 1) begin
            n_cmp++; if ({xen, yen, zen, xenc, yenc, zenc, correct_cnt, share_en} !== 9'b111000001) begin n_fail++; $display("FAIL corr_cycle1: got %b want 111000001", {xen, yen, zen, xenc, yenc, zenc, correct_cnt, share_en}); end
         end
         if (rel == 2) begin
            n_cmp++; if ({xen, yen, zen, xenc, share_en} !== 6'b100010) begin n_fail++; $display("FAIL corr_cycle2: got %b want 100010", {xen, yen, zen, xenc, share_en}); end
         end
         if (done === 1'b1) begin
            seen = 1;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL corr_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL corr_done: got cycle %0d want %0d", cyc, e); end end
            n_cmp++; if (share_en !== 2'b00 || xen !== 1'b0) begin n_fail++; $display("FAIL corr_exit: got %b/%b want 00/0", share_en, xen); end
         end
      end
      if (!seen) begin n_cmp++; n_fail++; $display("FAIL corr_done: got timeout want done"); end
   endtask

   task automatic test_back_to_back();
      int t, e, dones;
      dones = 0;
      issue(OP_INCR, 8'hA1, 1'b0, 2, t);
      for (int rel = 1; rel <= 10 && dones < 2; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         if (rel == 2) begin
            cmd_valid = 1'b1; cmd_op = OP_INIT; cmd_domain = 8'hB2;
            exp_done_q.push_back(t + 4);
         end
         #1;
         if (rel == 1) begin
            n_cmp++; if ({zen, zenc, correct_cnt, zrst, srst, domain} !== {5'b10100, 8'hA1}) begin n_fail++; $display("FAIL incr_cycle: got %b/%h want 10100/a1", {zen, zenc, correct_cnt, zrst, srst}, domain); end
         end
         if (rel == 2) begin
            n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
         end
         if (rel == 3) begin
            n_cmp++; if ({zen, correct_cnt, zrst, srst, domain} !== {4'b0011, 8'hB2}) begin n_fail++; $display("FAIL init_cycle: got %b/%h want 0011/b2", {zen, correct_cnt, zrst, srst}, domain); end
         end
         if (done === 1'b1) begin
            dones++;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL b2b_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL b2b_done: got cycle %0d want %0d", cyc, e); end end
         end
      end
      cmd_valid = 1'b0;
      if (dones < 2) begin n_cmp++; n_fail++; $display("FAIL b2b_done: got %0d dones want 2", dones); end

      dones = 0;
      issue(OP_NOP, 8'h33, 1'b0, 2, t);
      for (int rel = 1; rel <= 10 && dones < 1; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         #1;
         if (rel == 1) begin
            n_cmp++; if (all_outs !== {28'h0, 8'h33}) begin n_fail++; $display("FAIL nop_cycle: got %h want 33", all_outs); end
         end
         if (done === 1'b1) begin
            dones++;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL nop_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL nop_done: got cycle %0d want %0d", cyc, e); end end
         end
      end
      if (dones < 1) begin n_cmp++; n_fail++; $display("FAIL nop_done: got timeout want done"); end
   endtask

   task automatic test_rst_mid();
      int t, e, stray;
      bit seen;
      stray = 0; seen = 0;
      issue(OP_TBC, 8'h66, 1'b0, RUN_CYC + 1, t);
      for (int rel = 1; rel <= 50; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         if (rel == 50) rst = 1'b1;
         #1;
      end
      n_cmp++; if (erst !== 1'b1) begin n_fail++; $display("FAIL rst_erst: got %b want 1", erst); end
      @(posedge clk); #1; rst = 1'b0; #1;
      exp_done_q.delete();
      n_cmp++; if (all_outs !== '0) begin n_fail++; $display("FAIL rst_mid_outs: got %h want 0", all_outs); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); end
      for (int i = 0; i < 120; i++) begin
         @(posedge clk); #2;
         if (done === 1'b1) stray++;
      end
      n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses want 0", stray); end

      issue(OP_TBC, 8'h77, 1'b0, RUN_CYC + 1, t);
      for (int rel = 1; rel <= RUN_CYC + 10 && !seen; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         #1;
         if (rel == 1) begin
            n_cmp++; if (constant !== 6'h01) begin n_fail++; $display("FAIL restart_rc1: got %h want 01", constant); end
         end
         if (rel == 5) begin
            n_cmp++; if (constant !== 6'h03) begin n_fail++; $display("FAIL restart_rc2: got %h want 03", constant); end
         end
         if (done === 1'b1) begin
            seen = 1;
            n_cmp++;
            if (exp_done_q.size() == 0) begin n_fail++; $display("FAIL restart_done: got done at %0d want none", cyc); end
            else begin e = exp_done_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL restart_done: got cycle %0d want %0d", cyc, e); end end
         end
      end
      if (!seen) begin n_cmp++; n_fail++; $display("FAIL restart_done: got timeout want done"); end
   endtask

`ifdef ROMULUS_SEQ_ABORT_EN
   task automatic test_abort();
      int t, stray;
      stray = 0;
      issue(OP_TBC, 8'h88, 1'b0, RUN_CYC + 1, t);
      for (int rel = 1; rel <= 20; rel++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         if (rel == 20) abort = 1'b1;
         #1;
      end
      @(posedge clk); #1; abort = 1'b0; #1;
      exp_done_q.delete();
      n_cmp++; if ({aborted, done, cmd_ready} !== 3'b101) begin n_fail++; $display("FAIL abort_pulse: got %b want 101", {aborted, done, cmd_ready}); end
      n_cmp++; if (ring_en !== 4'b0 || constant !== 6'h0) begin n_fail++; $display("FAIL abort_clear: got %b/%h want 0/0", ring_en, constant); end
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #2;
         if (done === 1'b1 || aborted === 1'b1) stray++;
      end
      n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL abort_after: got %0d pulses want 0", stray); end
      @(posedge clk); #1; abort = 1'b1; #1;
      @(posedge clk); #1; abort = 1'b0; #1;
      n_cmp++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", aborted); end
   endtask
`endif

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_domain = 8'h00; cmd_iv = 1'b0; bus_valid = 1'b0;
`ifdef ROMULUS_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_tbc();
      test_key();
      test_tweak_absorb();
      test_corr();
      test_back_to_back();
      test_rst_mid();
`ifdef ROMULUS_SEQ_ABORT_EN
      test_abort();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish by 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
